// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM for the RV32I core: sequences each instruction
// through fetch/decode/execute/memory/writeback, drives the datapath control
// lines and memory strobes, counts retired instructions and traps on
// unsupported encodings.
module multicycle_ctrl #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           wb_sel,
    output logic                 pc_src,
    output logic                 illegal,
    output logic [3:0]           state,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_MEM_ADDR = 4'd4;
    localparam logic [3:0] S_MEM_RD   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_WB_ALU   = 4'd7;
    localparam logic [3:0] S_WB_MEM   = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;
    localparam logic [3:0] S_JALR     = 4'd11;
    localparam logic [3:0] S_LUI      = 4'd12;
    localparam logic [3:0] S_TRAP     = 4'd13;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic [3:0]           state_q, state_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 retire;

    // Next-state selection; TRAP and the unused codes only leave via reset.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (opcode)
                    OP_R:      state_d = S_EXEC_R;
                    OP_I:      state_d = S_EXEC_I;
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEM_ADDR;
                    OP_BRANCH: state_d = (funct3 == 3'b000 || funct3 == 3'b001) ? S_BRANCH : S_TRAP;
                    OP_JAL:    state_d = S_JAL;
                    OP_JALR:   state_d = S_JALR;
                    OP_LUI:    state_d = S_LUI;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I,
            S_LUI:      state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_WB_ALU,
            S_WB_MEM,
            S_BRANCH,
            S_JAL,
            S_JALR:     state_d = S_FETCH;
            default:    state_d = S_TRAP;
        endcase
    end

    // An instruction retires on the edge that returns any non-FETCH state to FETCH.
    assign retire    = (state_d == S_FETCH) && (state_q != S_FETCH);
    assign instret_d = retire ? instret_q + INSTRET_W'(1) : instret_q;

    // State and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Control decode of the current state, forced to all-zero while in reset.
    always_comb begin
        // NOTE: defaulting every output first keeps this block free of latches.
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        reg_write = 1'b0;
        alu_src_a = 2'd0;
        alu_src_b = 2'd0;
        alu_op    = 2'd0;
        wb_sel    = 2'd0;
        pc_src    = 1'b0;
        illegal   = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
            end
            S_EXEC_R: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd2;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                alu_op    = 2'd2;
            end
            S_LUI: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd2;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
            end
            S_MEM_RD:   mem_read  = 1'b1;
            S_MEM_WR:   mem_write = 1'b1;
            S_WB_ALU:   reg_write = 1'b1;
            S_WB_MEM: begin
                reg_write = 1'b1;
                wb_sel    = 2'd1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd1;
                alu_op    = 2'd1;
                pc_src    = 1'b1;
                pc_write  = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
            end
            S_JAL: begin
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
                pc_src    = 1'b1;
            end
            S_JALR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                reg_write = 1'b1;
                wb_sel    = 2'd2;
                pc_write  = 1'b1;
            end
            default:    illegal   = 1'b1;
        endcase
        if (!rst_n) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            alu_src_a = 2'd0;
            alu_src_b = 2'd0;
            alu_op    = 2'd0;
            wb_sel    = 2'd0;
            pc_src    = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state   = state_q;
    assign instret = instret_q;

endmodule
